// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Datapath control payload, excluding the ALU operation
    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       iord;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       illegal_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam int unsigned ALU_CODE_W = 4;

    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mc_aludec.sv
// ALU operation decoder: maps aluop and R-type funct to the ALU control code.
module mc_aludec
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  logic [5:0]           funct,
    input  logic [1:0]           aluop,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [ALU_CODE_W-1:0] code;

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   code = ALU_ADD;
                    F_SUB:   code = ALU_SUB;
                    F_AND:   code = ALU_AND;
                    F_OR:    code = ALU_OR;
                    F_SLT:   code = ALU_SLT;
                    // nor only exists when the ALU code is wide enough to carry it
                    F_NOR:   code = (ALUCTRL_W >= ALU_CODE_W) ? ALU_NOR : ALU_ADD;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode and the
// per-instruction execute/memory/writeback steps.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          EN_BNE    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 irwrite,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_op
);

    state_e                state_q, state_d;
    ctrl_t                 ctl;
    logic [1:0]            aluop;
    logic                  alu_en;
    logic [ALUCTRL_W-1:0]  alu_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        aluop   = ALUOP_ADD;
        alu_en  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctl.alusrcb = 2'b01;
                alu_en      = 1'b1;
                ctl.irwrite = mem_ready;
                ctl.pcen    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precompute while the opcode is examined
                ctl.alusrcb = 2'b11;
                alu_en      = 1'b1;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        state_d        = EN_BNE ? S_BRANCH : S_FETCH;
                        ctl.illegal_op = !EN_BNE;
                    end
                    default: begin
                        state_d        = S_FETCH;
                        ctl.illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                alu_en      = 1'b1;
                state_d     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                ctl.iord     = 1'b1;
                ctl.memwrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ctl.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
                alu_en      = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                alu_en      = 1'b1;
                ctl.pcsrc   = 2'b01;
                ctl.pcen    = (op == OP_BNE) ? ~zero : zero;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                alu_en      = 1'b1;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                ctl.pcsrc = 2'b10;
                ctl.pcen  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every output immediately, not just at the next edge
        if (!reset) begin
            ctl    = '0;
            alu_en = 1'b0;
        end
    end

    mc_aludec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alu_dec)
    );

    assign pcen       = ctl.pcen;
    assign irwrite    = ctl.irwrite;
    assign iord       = ctl.iord;
    assign memwrite   = ctl.memwrite;
    assign memtoreg   = ctl.memtoreg;
    assign regdst     = ctl.regdst;
    assign regwrite   = ctl.regwrite;
    assign alusrca    = ctl.alusrca;
    assign alusrcb    = ctl.alusrcb;
    assign pcsrc      = ctl.pcsrc;
    assign illegal_op = ctl.illegal_op;
    assign alucontrol = alu_en ? alu_dec : '0;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: two configurations (3-bit ALU code with
// bne, 4-bit ALU code without bne) against a per-instruction step model.
module tb_mc_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXECUTE, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} phase_t;

    typedef struct packed {
        logic       pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [3:0] alu;
        logic       illegal;
    } ctl_t;

    typedef struct {
        int         d;
        logic [5:0] op;
        logic [5:0] f;
        logic       z;
        int         cyc;
        int         ill;
        logic       rw;
        logic       mw;
        logic [3:0] alu;
        logic       pcen;
    } tvec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op[2], funct[2];
    logic       zero[2], mem_ready[2];
    logic       pcen[2], irwrite[2], iord[2], memwrite[2], memtoreg[2];
    logic       regdst[2], regwrite[2], alusrca[2], illegal_op[2];
    logic [1:0] alusrcb[2], pcsrc[2];
    logic [2:0] alu3;
    logic [3:0] alu4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_controller #(.ALUCTRL_W(3), .EN_BNE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .op(op[0]), .funct(funct[0]), .zero(zero[0]),
        .mem_ready(mem_ready[0]), .pcen(pcen[0]), .irwrite(irwrite[0]), .iord(iord[0]),
        .memwrite(memwrite[0]), .memtoreg(memtoreg[0]), .regdst(regdst[0]),
        .regwrite(regwrite[0]), .alusrca(alusrca[0]), .alusrcb(alusrcb[0]),
        .pcsrc(pcsrc[0]), .alucontrol(alu3), .illegal_op(illegal_op[0]));

    mc_controller #(.ALUCTRL_W(4), .EN_BNE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .op(op[1]), .funct(funct[1]), .zero(zero[1]),
        .mem_ready(mem_ready[1]), .pcen(pcen[1]), .irwrite(irwrite[1]), .iord(iord[1]),
        .memwrite(memwrite[1]), .memtoreg(memtoreg[1]), .regdst(regdst[1]),
        .regwrite(regwrite[1]), .alusrca(alusrca[1]), .alusrcb(alusrcb[1]),
        .pcsrc(pcsrc[1]), .alucontrol(alu4), .illegal_op(illegal_op[1]));

    function automatic ctl_t observe(int d);
        ctl_t a;
        a.pcen = pcen[d];         a.irwrite = irwrite[d];   a.iord = iord[d];
        a.memwrite = memwrite[d]; a.memtoreg = memtoreg[d]; a.regdst = regdst[d];
        a.regwrite = regwrite[d]; a.alusrca = alusrca[d];   a.alusrcb = alusrcb[d];
        a.pcsrc = pcsrc[d];       a.illegal = illegal_op[d];
        a.alu = (d == 0) ? {1'b0, alu3} : alu4;
        return a;
    endfunction

    // Configuration d=0: 3-bit codes, bne supported; d=1: 4-bit codes, bne illegal
    function automatic bit legal_op(logic [5:0] o, int d);
        return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) ||
               (o == JMP) || (o == BNE && d == 0);
    endfunction

    function automatic logic [3:0] alu_of_funct(logic [5:0] f, int d);
        case (f)
            6'b100000: return 4'h2;
            6'b100010: return 4'h6;
            6'b100100: return 4'h0;
            6'b100101: return 4'h1;
            6'b101010: return 4'h7;
            6'b100111: return (d == 1) ? 4'hC : 4'h2;
            default:   return 4'h2;
        endcase
    endfunction

    function automatic ctl_t expected(phase_t p, logic [5:0] o, logic [5:0] f, logic z,
                                      logic rdy, int d);
        ctl_t e = '0;
        case (p)
            P_FETCH:   begin e.alusrcb = 2'b01; e.alu = 4'h2; e.pcen = rdy; e.irwrite = rdy; end
            P_DECODE:  begin e.alusrcb = 2'b11; e.alu = 4'h2; e.illegal = !legal_op(o, d); end
            P_MEMADR,
            P_ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu = 4'h2; end
            P_MEMRD:   e.iord = 1'b1;
            P_MEMWR:   begin e.iord = 1'b1; e.memwrite = 1'b1; end
            P_MEMWB:   begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            P_ADDIWB:  e.regwrite = 1'b1;
            P_EXECUTE: begin e.alusrca = 1'b1; e.alu = alu_of_funct(f, d); end
            P_ALUWB:   begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            P_BRANCH:  begin
                e.alusrca = 1'b1; e.alu = 4'h6; e.pcsrc = 2'b01;
                e.pcen = (o == BNE) ? !z : z;
            end
            P_JUMP:    begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default:   e = '0;
        endcase
        return e;
    endfunction

    task automatic check(int d, ctl_t exp, string nm);
        ctl_t act = observe(d);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
        end
    endtask

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(int d, phase_t p, logic [5:0] o, logic [5:0] f, logic z, logic rdy);
        @(negedge clk);
        op[d] = o; funct[d] = f; zero[d] = z; mem_ready[d] = rdy;
        #1 check(d, expected(p, o, f, z, rdy, d), p.name());
    endtask

    // Walk one instruction through its phase list; memory phases hold until ready
    task automatic run_instr(int d, logic [5:0] o, logic [5:0] f, logic z, bit rnd);
        phase_t seq[$];
        int     waits;
        bit     rdy;
        bit     holds;
        seq.push_back(P_FETCH);
        seq.push_back(P_DECODE);
        if (o == LW) begin
            seq.push_back(P_MEMADR); seq.push_back(P_MEMRD); seq.push_back(P_MEMWB);
        end else if (o == SW) begin
            seq.push_back(P_MEMADR); seq.push_back(P_MEMWR);
        end else if (o == RT) begin
            seq.push_back(P_EXECUTE); seq.push_back(P_ALUWB);
        end else if (o == ADDI) begin
            seq.push_back(P_ADDIEX); seq.push_back(P_ADDIWB);
        end else if (o == JMP) begin
            seq.push_back(P_JUMP);
        end else if (o == BEQ || (o == BNE && d == 0)) begin
            seq.push_back(P_BRANCH);
        end
        foreach (seq[i]) begin
            waits = 0;
            holds = (seq[i] == P_FETCH) || (seq[i] == P_MEMRD) || (seq[i] == P_MEMWR);
            do begin
                rdy = !rnd || (waits >= 5) || ($urandom_range(0, 2) != 0);
                step(d, seq[i], o, f, z, rdy);
                waits++;
            end while (holds && !rdy);
        end
        @(posedge clk);
        #1 mem_ready[d] = 1'b0;
    endtask

    // Run one instruction with memory always ready and summarise what the DUT did
    task automatic measure(int row, tvec_t v);
        ctl_t a;
        ctl_t c3 = '0;
        int   cyc, ill;
        bit   rw, mw, done;
        @(negedge clk);
        op[v.d] = v.op; funct[v.d] = v.f; zero[v.d] = v.z; mem_ready[v.d] = 1'b1;
        #1 a = observe(v.d);
        cyc = 1; ill = int'(a.illegal); rw = a.regwrite; mw = a.memwrite; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            #1 a = observe(v.d);
            if (a.irwrite) begin
                done = 1'b1;
            end else begin
                cyc++;
                ill += int'(a.illegal);
                rw |= a.regwrite;
                mw |= a.memwrite;
                if (cyc == 3) c3 = a;
            end
        end
        mem_ready[v.d] = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL row%0d_timeout: no return to fetch within 20 cycles", row);
        end
        cmp($sformatf("row%0d_cycles", row), cyc, v.cyc);
        cmp($sformatf("row%0d_illegal", row), ill, v.ill);
        cmp($sformatf("row%0d_regwrite", row), int'(rw), int'(v.rw));
        cmp($sformatf("row%0d_memwrite", row), int'(mw), int'(v.mw));
        if (v.cyc >= 3) begin
            cmp($sformatf("row%0d_alu_c3", row), int'(c3.alu), int'(v.alu));
            cmp($sformatf("row%0d_pcen_c3", row), int'(c3.pcen), int'(v.pcen));
        end
    endtask

    task automatic run_random(int n);
        logic [5:0] ops[7];
        logic [5:0] fns[7];
        logic [5:0] o, f;
        int         d;
        ops = '{LW, SW, RT, BEQ, BNE, ADDI, JMP};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
        for (int i = 0; i < n; i++) begin
            d = int'($urandom_range(0, 1));
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            f = ($urandom_range(0, 1) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr(d, o, f, 1'($urandom), 1'b1);
        end
    endtask

    tvec_t tab[18];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{0, LW,   6'b000000, 1'b0, 5, 0, 1'b1, 1'b0, 4'h2, 1'b0};
        tab[1]  = '{0, SW,   6'b000000, 1'b0, 4, 0, 1'b0, 1'b1, 4'h2, 1'b0};
        tab[2]  = '{0, RT,   6'b100010, 1'b0, 4, 0, 1'b1, 1'b0, 4'h6, 1'b0};
        tab[3]  = '{0, RT,   6'b100100, 1'b0, 4, 0, 1'b1, 1'b0, 4'h0, 1'b0};
        tab[4]  = '{0, RT,   6'b100101, 1'b0, 4, 0, 1'b1, 1'b0, 4'h1, 1'b0};
        tab[5]  = '{0, RT,   6'b101010, 1'b0, 4, 0, 1'b1, 1'b0, 4'h7, 1'b0};
        tab[6]  = '{0, RT,   6'b100111, 1'b0, 4, 0, 1'b1, 1'b0, 4'h2, 1'b0};
        tab[7]  = '{1, RT,   6'b100111, 1'b0, 4, 0, 1'b1, 1'b0, 4'hC, 1'b0};
        tab[8]  = '{1, RT,   6'b000000, 1'b0, 4, 0, 1'b1, 1'b0, 4'h2, 1'b0};
        tab[9]  = '{0, BEQ,  6'b000000, 1'b1, 3, 0, 1'b0, 1'b0, 4'h6, 1'b1};
        tab[10] = '{0, BEQ,  6'b000000, 1'b0, 3, 0, 1'b0, 1'b0, 4'h6, 1'b0};
        tab[11] = '{0, BNE,  6'b000000, 1'b1, 3, 0, 1'b0, 1'b0, 4'h6, 1'b0};
        tab[12] = '{0, BNE,  6'b000000, 1'b0, 3, 0, 1'b0, 1'b0, 4'h6, 1'b1};
        tab[13] = '{1, BNE,  6'b000000, 1'b1, 2, 1, 1'b0, 1'b0, 4'h0, 1'b0};
        tab[14] = '{0, ADDI, 6'b000000, 1'b0, 4, 0, 1'b1, 1'b0, 4'h2, 1'b0};
        tab[15] = '{0, JMP,  6'b000000, 1'b0, 3, 0, 1'b0, 1'b0, 4'h0, 1'b1};
        tab[16] = '{0, BAD,  6'b000000, 1'b0, 2, 1, 1'b0, 1'b0, 4'h0, 1'b0};
        tab[17] = '{1, BEQ,  6'b000000, 1'b1, 3, 0, 1'b0, 1'b0, 4'h6, 1'b1};

        // Reset held with memory ready and a live opcode: everything must stay quiet
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            op[d] = LW; funct[d] = 6'b0; zero[d] = 1'b0; mem_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check(0, '0, "reset_outputs");
        check(1, '0, "reset_outputs");
        mem_ready[0] = 1'b0; mem_ready[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // lw with memory always ready: five cycles, writeback in the last
        run_instr(0, LW, 6'b0, 1'b0, 1'b0);

        // lw stalled two cycles in MEMRD: seven cycles, no early writeback
        step(0, P_FETCH,  LW, 6'b0, 1'b0, 1'b1);
        step(0, P_DECODE, LW, 6'b0, 1'b0, 1'b1);
        step(0, P_MEMADR, LW, 6'b0, 1'b0, 1'b1);
        step(0, P_MEMRD,  LW, 6'b0, 1'b0, 1'b0);
        step(0, P_MEMRD,  LW, 6'b0, 1'b0, 1'b0);
        step(0, P_MEMRD,  LW, 6'b0, 1'b0, 1'b1);
        step(0, P_MEMWB,  LW, 6'b0, 1'b0, 1'b0);
        step(0, P_FETCH,  LW, 6'b0, 1'b0, 1'b0);

        foreach (tab[i]) measure(i, tab[i]);

        // sw stalled in MEMWR, then reset mid-cycle kills memwrite at once
        step(0, P_FETCH,  SW, 6'b0, 1'b0, 1'b1);
        step(0, P_DECODE, SW, 6'b0, 1'b0, 1'b0);
        step(0, P_MEMADR, SW, 6'b0, 1'b0, 1'b0);
        step(0, P_MEMWR,  SW, 6'b0, 1'b0, 1'b0);
        step(0, P_MEMWR,  SW, 6'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 check(0, '0, "reset_mid_memwr");
        check(1, '0, "reset_mid_memwr");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_instr(0, LW, 6'b0, 1'b0, 1'b0);

        run_random(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL be clocked by one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter ALUCTRL_W, default 3, SHALL set the alucontrol width (legal 3..4).
REQ-003 Parameter EN_BNE, default 1, SHALL enable bne (op 000101) decoding.
REQ-004 Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26], sampled from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pcen  out  1  PC register enable
- irwrite  out  1  instruction register load
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- memtoreg  out  1  register writeback source: 1 = data register
- regdst  out  1  destination: 1 = rd, 0 = rt
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B: 00 = reg B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  ALUCTRL_W  ALU operation
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Function
REQ-005 Multicycle Moore FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-006 Transitions: FETCH->DECODE when mem_ready=1, else hold; DECODE-> MEMADR (lw 100011/sw 101011), EXECUTE (R-type 000000), BRANCH (beq 000100; bne if EN_BNE), ADDIEX (addi 001000), JUMP (j 000010), FETCH otherwise.
REQ-007 MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB when mem_ready=1, else hold; MEMWR->FETCH when mem_ready=1, else hold; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-008 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, pcsrc=00, ALU add; irwrite and pcen SHALL be 1 only in the FETCH cycle where mem_ready=1.
REQ-009 DECODE SHALL drive alusrca=0, alusrcb=11, ALU add (branch target precompute).
REQ-010 MEMADR/ADDIEX: alusrca=1, alusrcb=10, add. MEMRD: iord=1. MEMWR: iord=1, memwrite=1 every cycle until mem_ready=1. MEMWB: regwrite=1, memtoreg=1, regdst=0. ADDIWB: regwrite=1, memtoreg=0, regdst=0.
REQ-011 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct. ALUWB: regwrite=1, regdst=1, memtoreg=0.
REQ-012 BRANCH: alusrca=1, alusrcb=00, subtract, pcsrc=01; pcen = zero for beq, ~zero for bne (combinational on zero). JUMP: pcsrc=10, pcen=1.
REQ-013 funct decode: 100000 add=010, 100010 sub=110, 100100 and=000, 100101 or=001, 101010 slt=111; 100111 nor=1100 only when ALUCTRL_W=4; unknown funct SHALL yield add and no illegal_op.
REQ-014 When ALUCTRL_W=4, the 3-bit codes SHALL be zero-extended.
REQ-015 illegal_op SHALL pulse 1 for exactly the DECODE cycle on an unsupported opcode (including bne when EN_BNE=0); no register or memory write SHALL follow.
REQ-016 Unlisted outputs SHALL be 0 in every state; no output SHALL depend on mem_ready outside FETCH, MEMRD and MEMWR.

Reset
REQ-017 reset=0 SHALL force state to FETCH and all outputs to 0 immediately, independent of clk, including mid-MEMWR.
REQ-018 The first FETCH after reset release SHALL behave per REQ-008 on the first rising edge.

Structure
REQ-019 Shared package mc_pkg SHALL hold the state enum, opcode/funct constants, aluop encoding, and ALU code constants.
REQ-020 ALU decode SHALL be a sub-module mc_aludec (inputs funct and aluop; output alucontrol, parametrised by ALUCTRL_W).

Verification
REQ-021 lw, mem_ready=1 constantly -> FETCH,DECODE,MEMADR,MEMRD,MEMWB = 5 cycles; regwrite=1 and memtoreg=1 in cycle 5.
REQ-022 lw, mem_ready=0 for 2 cycles in MEMRD -> 7 cycles total; MEMWB is not entered early.
REQ-023 beq, zero=1 -> pcen=1, pcsrc=01 in BRANCH; bne, zero=1 -> pcen=0; with EN_BNE=0, bne -> illegal_op pulse.
REQ-024 op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; regwrite and memwrite stay 0.
REQ-025 R-type funct=100111 with ALUCTRL_W=4 -> alucontrol=1100 in EXECUTE; with ALUCTRL_W=3 -> 010.
REQ-026 sw with mem_ready=0, reset asserted in MEMWR -> memwrite=0 in the same cycle; after release the controller starts in FETCH.
